ram_dp_param: RTL
=================

// Module: ram_dp_param
// PURPOSE
//   Parametrised simple dual-port synchronous RAM: one write port, one read port, one clock.
//   Successor to the single-port 16x8 RAM. Adds configurable width/depth, byte enables,
//   a 1- or 2-cycle registered read with valid flag, a read-during-write mode, and an
//   automatic post-reset clear engine. Serves as the general on-chip storage primitive.
// PARAMETERS
//   DATA_W    32  data width in bits; must be a multiple of 8
//   ADDR_W    4   address width; DEPTH = 2**ADDR_W words
//   RD_LAT    1   read latency in cycles; legal values 1 or 2
//   RDW_MODE  0   same-address read/write collision: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)
// PORTS
//   clk       in   1          single clock; all logic on the rising edge
//   rst       in   1          synchronous, active-high reset
//   wr_en     in   1          write request
//   wr_addr   in   ADDR_W     write address
//   wr_data   in   DATA_W     write data
//   wr_be     in   DATA_W/8   byte enables; bit i enables wr_data[8i+7:8i]
//   rd_en     in   1          read request
//   rd_addr   in   ADDR_W     read address
//   rd_data   out  DATA_W     read data; valid when rd_valid=1
//   rd_valid  out  1          one-cycle pulse per accepted read
//   busy      out  1          clear engine active; all requests dropped
// BEHAVIOUR
//   Reset values: rd_data=0, rd_valid=0, busy=1, clear counter=0, FSM=CLEAR, read pipe flushed.
//   FSM: CLEAR -> READY.
//     CLEAR: writes 0 to word clr_cnt each cycle, clr_cnt 0..DEPTH-1. At DEPTH-1, FSM -> READY
//       next cycle, busy->0. busy high for exactly DEPTH cycles after rst deasserts.
//     READY: normal operation; stays until rst.
//   rst asserted in any state (including mid-clear) restarts CLEAR from word 0 and flushes
//     in-flight reads (rd_valid=0 on the following cycle).
//   While busy=1: wr_en and rd_en are ignored. No write, no rd_valid; a request is not queued.
//   Write: wr_en=1 in READY at edge N updates only the bytes with wr_be=1. wr_be=0 is a no-op.
//   Read: rd_en=1 at edge N gives rd_valid=1 and rd_data=mem[rd_addr] after edge N+RD_LAT-1,
//     i.e. visible in cycle N+RD_LAT. Back-to-back reads are fully pipelined: one per cycle.
//   rd_data holds its last value while rd_valid=0; it is not zeroed.
//   Collision (wr_en & rd_en & wr_addr==rd_addr, same edge):
//     RDW_MODE=0 returns the pre-write word.
//     RDW_MODE=1 returns the merged word: new bytes where wr_be=1, old bytes elsewhere.
//   The write always completes in both modes.
//   Different-address simultaneous read/write is independent.
//   Addresses wrap naturally. No out-of-range case, since DEPTH = 2**ADDR_W.
//   Illegal parameters (RD_LAT not 1/2, DATA_W%8 != 0) raise an elaboration-time $error.
// STRUCTURE
//   Package ram_pkg:
//     FSM state constants (ST_CLEAR, ST_READY)
//     RDW_READ_FIRST / RDW_WRITE_FIRST constants
//     BYTE_W = 8
//   Top: memory array, byte-enable write merge, clear FSM/counter, collision bypass mux.
//   Sub-module ram_rd_pipe: RD_LAT-deep valid/data delay line with sync flush.
//     Instantiated once on the read path.
// TESTING (DATA_W=32, ADDR_W=4 unless stated)
//   1 Reset then idle:
//     busy=1 for 16 cycles then 0.
//     Read every address -> all return 0x00000000 with rd_valid, RD_LAT after rd_en.
//   2 Write 0x000000AB @2, be=4'b1111.
//     Then write 0xCD000000 @2, be=4'b1000.
//     Then read @2 -> 0xCD0000AB, rd_valid one pulse at cycle N+RD_LAT.
//   3 Collision: @4 holds 0x11111111.
//     Same edge: wr 0x22222222 be=1111 and rd @4.
//     RDW_MODE=0 -> 0x11111111; RDW_MODE=1 -> 0x22222222.
//     Following read -> 0x22222222.
//   4 RD_LAT=2: reads @0,1,2 on consecutive cycles.
//     -> three consecutive rd_valid pulses starting 2 cycles later, data in order.
//   5 Requests during busy: wr_en=1 @3 data 0xFFFFFFFF and rd_en=1 while busy=1.
//     -> no rd_valid; after clear, read @3 -> 0x00000000.
//   6 Mid-operation reset: rst for 1 cycle at clear count 7, plus a read in flight in READY.
//     -> rd_valid suppressed; busy high 16 more cycles; all words read 0.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and types for the dual-port RAM
//
// Purpose: common definitions for ram_dp_param and its read pipeline.
//   BYTE_W           width of one byte lane
//   RDW_READ_FIRST   collision returns the pre-write word
//   RDW_WRITE_FIRST  collision returns the byte-merged new word
//   state_e          clear-engine FSM states (ST_CLEAR, ST_READY)
// Ports: none.

package ram_pkg;

    localparam int BYTE_W          = 8;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - LAT-deep valid/data delay line with synchronous flush
//
// Purpose: carries each accepted read word and its valid flag through LAT
//   register stages. Data registers only load when the incoming stage is
//   valid, so the output word holds its last value between reads.
// Ports:
//   clk_i    in   clock, rising edge
//   flush_i  in   synchronous flush; clears every stage (valid and data)
//   valid_i  in   read accepted this cycle
//   data_i   in   word read this cycle
//   valid_o  out  valid flag after LAT stages
//   data_o   out  data after LAT stages; held while valid_o is low

module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LAT-1:0]             vld_q;
    logic [LAT-1:0][DATA_W-1:0] dat_q;

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            if (valid_i) begin
                dat_q[0] <= data_i;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign valid_o = vld_q[LAT-1];
    assign data_o  = dat_q[LAT-1];

endmodule

// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - parametrised simple dual-port RAM with clear engine
//
// Purpose: one write port, one read port, one clock. Byte-enabled writes,
//   1- or 2-cycle registered reads with a valid pulse, selectable
//   read-during-write behaviour, and a post-reset engine that zeroes every
//   word before requests are accepted.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset; restarts the clear engine
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_data   in   write data
//   wr_be     in   byte enables, bit i covers wr_data[8i+7:8i]
//   rd_en     in   read request
//   rd_addr   in   read address
//   rd_data   out  read data, valid when rd_valid is high
//   rd_valid  out  one pulse per accepted read, RD_LAT cycles after rd_en
//   busy      out  clear engine running; requests are dropped

module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / BYTE_W;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("ram_dp_param: RD_LAT must be 1 or 2");
    end
    if (DATA_W % BYTE_W != 0) begin : g_bad_data_w
        $error("ram_dp_param: DATA_W must be a multiple of 8");
    end
    if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
        $error("ram_dp_param: RDW_MODE must be 0 or 1");
    end

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_acc;
    logic                rd_acc;
    logic                collide;
    logic [DATA_W-1:0]   wr_merged_d;
    logic [DATA_W-1:0]   rd_word_d;

    assign busy = (state_q == ST_CLEAR);

    // Requests arriving with rst high are dropped as well: the clear engine
    // is about to restart and must not race a user write.
    assign wr_acc  = wr_en & ~busy & ~rst;
    assign rd_acc  = rd_en & ~busy & ~rst;
    assign collide = wr_acc & rd_acc & (wr_addr == rd_addr);

    // Old word with the enabled byte lanes replaced; used both as the value
    // stored and as the write-first bypass word.
    always_comb begin
        wr_merged_d = mem_q[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                wr_merged_d[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        rd_word_d = mem_q[rd_addr];
        if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
            rd_word_d = wr_merged_d;
        end
    end

    // Clear engine: walks clr_cnt_q over every word, then parks in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (busy && !rst) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_merged_d;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk),
        .flush_i (rst),
        .valid_i (rd_acc),
        .data_i  (rd_word_d),
        .valid_o (rd_valid),
        .data_o  (rd_data)
    );

endmodule
